// File: rtl/tekram_pkg.sv
// Shared definitions for the tekram RAM and its host-side initiator:
// the initiator state encoding and the default bus geometry.
package tekram_pkg;

   localparam int ADDR_WIDTH = 4;
   localparam int DATA_WIDTH = 16;
   localparam int LEN_WIDTH  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      TURN = 2'd3
   } state_e;

endpackage

// File: rtl/tekram_rsp_slot.sv
// One-entry valid/ready response register carrying read data and a last flag.
// valid_next_o exposes the slot's occupancy for the coming cycle so the issuer can plan ahead.
module tekram_rsp_slot #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  load_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  last_i,
   input  logic                  ready_i,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  last_o,
   output logic                  valid_next_o
);

   logic                  valid_q;
   logic                  valid_d;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  last_q;

   // A load on the same edge as a pop keeps the slot full with the new beat.
   always_comb begin
      // NOTE: assign a default before any conditional update so the block
      // cannot infer a latch on the paths that leave valid_d untouched.
      valid_d = valid_q;
      if (load_i) begin
         valid_d = 1'b1;
      end else if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (load_i) begin
            data_q <= data_i;
            last_q <= last_i;
         end
      end
   end

   assign valid_o      = valid_q;
   assign data_o       = data_q;
   assign last_o       = last_q;
   assign valid_next_o = valid_d;

endmodule

// File: rtl/tekram_initiator.sv
// Host-side tekram bus controller: single-beat writes, incrementing read bursts,
// registered RAM strobes and a turnaround cycle after every operation.
module tekram_initiator
   import tekram_pkg::*;
#(
   parameter int ADDR_WIDTH = tekram_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = tekram_pkg::DATA_WIDTH,
   parameter int LEN_WIDTH  = tekram_pkg::LEN_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [LEN_WIDTH-1:0]  req_len,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_last,
   output logic                  busy,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_cs,
   output logic                  mem_wr,
   output logic                  mem_oe,
   inout  logic [DATA_WIDTH-1:0] mem_data
);

   localparam int CNT_WIDTH = LEN_WIDTH + 1;

   state_e                state_q;
   state_e                state_d;

   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [CNT_WIDTH-1:0]  remain_q;
   logic                  last_inflight_q;

   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic                  mem_cs_q;
   logic                  mem_wr_q;
   logic                  mem_oe_q;
   logic                  mem_cs_d;
   logic                  mem_wr_d;
   logic                  mem_oe_d;

   logic                  accept;
   logic                  issue;
   logic                  capture;
   logic                  slot_valid_next;

   assign accept  = req_valid && req_ready;
   assign capture = mem_cs_q && mem_oe_q;

   // ---------------- state register ----------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignment so every register
      // samples pre-edge values regardless of process evaluation order.
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: if (accept) state_d = req_we ? WR : RD;
         WR:   state_d = TURN;
         RD:   if (capture && last_inflight_q) state_d = TURN;
         TURN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- output logic ----------------
   // Strobes are registered, so a beat is planned one cycle ahead: it may only
   // go out if the response slot will be empty during the bus cycle itself.
   always_comb begin
      req_ready = rst_n && (state_q == IDLE);
      busy      = (state_q != IDLE);
      issue     = (state_q == RD) && (remain_q != '0) && !slot_valid_next;
      mem_cs_d  = (state_q == WR) || issue;
      mem_wr_d  = (state_q == WR);
      mem_oe_d  = issue;
   end

   // ---------------- datapath and bus registers ----------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q          <= '0;
         wdata_q         <= '0;
         remain_q        <= '0;
         last_inflight_q <= 1'b0;
         mem_addr_q      <= '0;
         mem_cs_q        <= 1'b0;
         mem_wr_q        <= 1'b0;
         mem_oe_q        <= 1'b0;
      end else begin
         mem_cs_q <= mem_cs_d;
         mem_wr_q <= mem_wr_d;
         mem_oe_q <= mem_oe_d;

         if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            remain_q <= req_we ? '0 : CNT_WIDTH'(req_len) + CNT_WIDTH'(1);
         end

         if (state_q == WR) begin
            mem_addr_q <= addr_q;
         end

         // Address wraps naturally at 2^ADDR_WIDTH; wait cycles hold mem_addr.
         if (issue) begin
            mem_addr_q      <= addr_q;
            addr_q          <= addr_q + ADDR_WIDTH'(1);
            remain_q        <= remain_q - CNT_WIDTH'(1);
            last_inflight_q <= (remain_q == CNT_WIDTH'(1));
         end
      end
   end

   assign mem_addr = mem_addr_q;
   assign mem_cs   = mem_cs_q;
   assign mem_wr   = mem_wr_q;
   assign mem_oe   = mem_oe_q;

   // Drive only during a write cycle; mem_wr and mem_oe are never both set.
   assign mem_data = (mem_cs_q && mem_wr_q) ? wdata_q : {DATA_WIDTH{1'bz}};

   tekram_rsp_slot #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rsp_slot (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_i       (capture),
      .data_i       (mem_data),
      .last_i       (last_inflight_q),
      .ready_i      (rsp_ready),
      .valid_o      (rsp_valid),
      .data_o       (rsp_rdata),
      .last_o       (rsp_last),
      .valid_next_o (slot_valid_next)
   );

endmodule

// File: tb/tb_tekram_initiator.sv
// Directed bench for tekram_initiator with a behavioural tekram RAM on the bus.
module tb_tekram_initiator;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [3:0]  req_addr;
   logic [15:0] req_wdata;
   logic [3:0]  req_len;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [15:0] rsp_rdata;
   logic        rsp_last;
   logic        busy;
   logic [3:0]  mem_addr;
   logic        mem_cs;
   logic        mem_wr;
   logic        mem_oe;
   wire  [15:0] mem_data;

   int vec_cnt = 0;
   int err_cnt = 0;

   tekram_initiator dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_len   (req_len),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .rsp_last  (rsp_last),
      .busy      (busy),
      .mem_addr  (mem_addr),
      .mem_cs    (mem_cs),
      .mem_wr    (mem_wr),
      .mem_oe    (mem_oe),
      .mem_data  (mem_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: drives read data only in the second half of an oe cycle.
   logic [15:0] ram [16];
   logic        half_q = 1'b0;
   logic [15:0] ram_rd;
   always @(clk) half_q <= ~clk;
   assign ram_rd   = ram[mem_addr];
   assign mem_data = (half_q && mem_cs && mem_oe && !mem_wr) ? ram_rd : 16'hzzzz;
   always @(posedge clk) if (mem_cs && mem_wr) ram[mem_addr] <= mem_data;

   typedef struct { logic [15:0] data; logic last; time t; } rsp_t;
   typedef struct { logic [3:0] addr; logic [15:0] data; time t; } wr_t;
   rsp_t        rsp_q[$];
   wr_t         wr_q[$];
   logic [3:0]  iss_q[$];
   time         iss_t_q[$];
   time         acc_q[$];
   int          contention = 0;

   always @(posedge clk) begin
      if (rsp_valid && rsp_ready) rsp_q.push_back('{rsp_rdata, rsp_last, $time});
      if (req_valid && req_ready) acc_q.push_back($time);
      if (mem_cs && mem_wr) wr_q.push_back('{mem_addr, mem_data, $time});
      if (mem_cs && mem_oe) begin
         iss_q.push_back(mem_addr);
         iss_t_q.push_back($time);
      end
   end

   always @(negedge clk) if (mem_oe && mem_wr) contention <= contention + 1;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
      $fatal(1);
   end

   task automatic clear_logs();
      rsp_q.delete(); wr_q.delete(); iss_q.delete(); iss_t_q.delete(); acc_q.delete();
   endtask

   task automatic send_req(input logic we, input logic [3:0] addr, input logic [15:0] wdata,
                           input logic [3:0] len, output time acc_t);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_len = len;
      while (!req_ready && n < 100) begin @(negedge clk); n++; end
      if (!req_ready) begin
         vec_cnt++; err_cnt++;
         $display("FAIL accept_timeout: req_ready=%b, required 1", req_ready);
      end
      @(posedge clk);
      acc_t = $time;
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic wait_rsp(input int n);
      int k = 0;
      while (rsp_q.size() < n && k < 300) begin @(negedge clk); k++; end
      if (rsp_q.size() < n) begin
         vec_cnt++; err_cnt++;
         $display("FAIL rsp_timeout: got %0d responses, required %0d", rsp_q.size(), n);
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      @(negedge clk);
      while ((busy || mem_cs) && k < 300) begin @(negedge clk); k++; end
      if (busy || mem_cs) begin
         vec_cnt++; err_cnt++;
         $display("FAIL idle_timeout: busy=%b, required 0", busy);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; req_len = '0; rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      vec_cnt++;
      if (req_ready !== 1'b0) begin
         err_cnt++; $display("FAIL reset_req_ready: got %b, required 0", req_ready);
      end
      vec_cnt++;
      if ({busy, mem_cs, mem_wr, mem_oe, mem_addr, rsp_valid, rsp_last, rsp_rdata} !== '0) begin
         err_cnt++;
         $display("FAIL reset_outputs: got busy=%b cs=%b wr=%b oe=%b addr=%h v=%b l=%b d=%h, required all 0",
                  busy, mem_cs, mem_wr, mem_oe, mem_addr, rsp_valid, rsp_last, rsp_rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      vec_cnt++;
      if (req_ready !== 1'b1) begin
         err_cnt++; $display("FAIL post_reset_ready: got %b, required 1", req_ready);
      end
   endtask

   task automatic test_write_read();
      time e;
      clear_logs();
      send_req(1'b1, 4'h3, 16'hBEEF, 4'h0, e);
      @(negedge clk);
      vec_cnt++;
      if (req_ready !== 1'b0) begin
         err_cnt++; $display("FAIL wr_ready_turn: got %b at E+15, required 0", req_ready);
      end
      @(negedge clk);
      vec_cnt++;
      if (req_ready !== 1'b1) begin
         err_cnt++; $display("FAIL wr_ready_again: got %b at E+25, required 1", req_ready);
      end
      wait_idle();
      vec_cnt++;
      if (wr_q.size() != 1 || wr_q[0].addr !== 4'h3 || wr_q[0].data !== 16'hBEEF || wr_q[0].t != e + 20) begin
         err_cnt++;
         $display("FAIL wr_pulse: got %0d pulses first addr=%h data=%h t=%0t, required 1 pulse addr=3 data=beef t=%0t",
                  wr_q.size(), wr_q.size() ? wr_q[0].addr : 4'h0, wr_q.size() ? wr_q[0].data : 16'h0,
                  wr_q.size() ? wr_q[0].t : 0, e + 20);
      end
      send_req(1'b0, 4'h3, 16'h0, 4'h0, e);
      wait_rsp(1);
      wait_idle();
      vec_cnt++;
      if (rsp_q.size() != 1 || rsp_q[0].data !== 16'hBEEF || rsp_q[0].last !== 1'b1 || rsp_q[0].t != e + 30) begin
         err_cnt++;
         $display("FAIL rd_single: got n=%0d data=%h last=%b t=%0t, required n=1 data=beef last=1 t=%0t",
                  rsp_q.size(), rsp_q.size() ? rsp_q[0].data : 16'h0, rsp_q.size() ? rsp_q[0].last : 1'b0,
                  rsp_q.size() ? rsp_q[0].t : 0, e + 30);
      end
   endtask

   task automatic test_wrap();
      time e;
      logic [15:0] exp_d [4] = '{16'h100E, 16'h100F, 16'h1000, 16'h1001};
      logic [3:0]  exp_a [4] = '{4'hE, 4'hF, 4'h0, 4'h1};
      for (int i = 0; i < 4; i++) send_req(1'b1, exp_a[i], exp_d[i], 4'h0, e);
      wait_idle();
      clear_logs();
      send_req(1'b0, 4'hE, 16'h0, 4'h3, e);
      wait_rsp(4);
      wait_idle();
      vec_cnt++;
      if (iss_q.size() != 4 || {iss_q[0], iss_q[1], iss_q[2], iss_q[3]} !== 16'hEF01) begin
         err_cnt++; $display("FAIL wrap_addr: got %0d issues, addresses %p, required e f 0 1", iss_q.size(), iss_q);
      end
      if (rsp_q.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if (rsp_q[i].data !== exp_d[i] || rsp_q[i].last !== (i == 3)) begin
               err_cnt++;
               $display("FAIL wrap_beat%0d: got data=%h last=%b, required data=%h last=%b",
                        i, rsp_q[i].data, rsp_q[i].last, exp_d[i], i == 3);
            end
         end
         vec_cnt++;
         if (rsp_q[1].t - rsp_q[0].t != 20) begin
            err_cnt++; $display("FAIL wrap_rate: got beat spacing %0t, required 20", rsp_q[1].t - rsp_q[0].t);
         end
      end
   endtask

   task automatic test_stall();
      time e;
      int k = 0;
      logic stable = 1'b1;
      logic cs_seen = 1'b0;
      clear_logs();
      rsp_ready = 1'b0;
      send_req(1'b0, 4'hE, 16'h0, 4'h3, e);
      while (!rsp_valid && k < 50) begin @(negedge clk); k++; end
      vec_cnt++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h100E) begin
         err_cnt++; $display("FAIL stall_first: got valid=%b data=%h, required valid=1 data=100e", rsp_valid, rsp_rdata);
      end
      if (mem_cs) cs_seen = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (rsp_valid !== 1'b1 || rsp_rdata !== 16'h100E || rsp_last !== 1'b0) stable = 1'b0;
         if (mem_cs) cs_seen = 1'b1;
      end
      vec_cnt++;
      if (stable !== 1'b1) begin
         err_cnt++; $display("FAIL stall_hold: got stable=%b, required 1", stable);
      end
      vec_cnt++;
      if (cs_seen !== 1'b0) begin
         err_cnt++; $display("FAIL stall_no_cs: got cs during stall=%b, required 0", cs_seen);
      end
      rsp_ready = 1'b1;
      wait_rsp(4);
      wait_idle();
      vec_cnt++;
      if (rsp_q.size() != 4 ||
          {rsp_q[0].data, rsp_q[1].data, rsp_q[2].data, rsp_q[3].data, rsp_q[3].last}
          !== {16'h100E, 16'h100F, 16'h1000, 16'h1001, 1'b1}) begin
         err_cnt++; $display("FAIL stall_resume: got %0d beats %p, required 100e 100f 1000 1001 last", rsp_q.size(), rsp_q);
      end
   endtask

   task automatic test_back_to_back();
      time e;
      clear_logs();
      rsp_ready = 1'b1;
      send_req(1'b0, 4'h3, 16'h0, 4'h0, e);
      send_req(1'b1, 4'h5, 16'h1234, 4'h0, e);
      wait_idle();
      vec_cnt++;
      if (iss_t_q.size() != 1 || wr_q.size() != 1 || wr_q[0].t < iss_t_q[0] + 20) begin
         err_cnt++;
         $display("FAIL b2b_turn: got %0d reads %0d writes gap=%0t, required 1/1 gap>=20",
                  iss_t_q.size(), wr_q.size(),
                  (iss_t_q.size() && wr_q.size()) ? wr_q[0].t - iss_t_q[0] : 0);
      end
      vec_cnt++;
      if (rsp_q.size() != 1 || rsp_q[0].data !== 16'hBEEF) begin
         err_cnt++; $display("FAIL b2b_rdata: got n=%0d data=%h, required n=1 data=beef",
                             rsp_q.size(), rsp_q.size() ? rsp_q[0].data : 16'h0);
      end
      vec_cnt++;
      if (contention != 0) begin
         err_cnt++; $display("FAIL bus_contention: got %0d cycles with oe&&wr, required 0", contention);
      end
   endtask

   task automatic test_reset_mid_burst();
      time e;
      int k = 0;
      int n_rsp;
      clear_logs();
      rsp_ready = 1'b1;
      send_req(1'b0, 4'hE, 16'h0, 4'h7, e);
      while (!(mem_cs && mem_oe && iss_q.size() == 1) && k < 100) begin @(negedge clk); k++; end
      vec_cnt++;
      if (!(mem_cs && mem_oe)) begin
         err_cnt++; $display("FAIL rst_beat2_seen: got cs=%b oe=%b, required both 1", mem_cs, mem_oe);
      end
      rst_n = 1'b0;
      n_rsp = rsp_q.size();
      @(negedge clk);
      vec_cnt++;
      if ({busy, mem_cs, mem_wr, mem_oe, mem_addr, rsp_valid, rsp_last, rsp_rdata, req_ready} !== '0) begin
         err_cnt++;
         $display("FAIL rst_mid_outputs: got busy=%b cs=%b wr=%b oe=%b addr=%h v=%b l=%b d=%h rdy=%b, required all 0",
                  busy, mem_cs, mem_wr, mem_oe, mem_addr, rsp_valid, rsp_last, rsp_rdata, req_ready);
      end
      rst_n = 1'b1;
      #1;
      vec_cnt++;
      if (req_ready !== 1'b1) begin
         err_cnt++; $display("FAIL rst_release_ready: got %b, required 1", req_ready);
      end
      repeat (10) @(negedge clk);
      vec_cnt++;
      if (rsp_q.size() != n_rsp) begin
         err_cnt++; $display("FAIL rst_no_more_beats: got %0d responses, required %0d", rsp_q.size(), n_rsp);
      end
      send_req(1'b0, 4'h5, 16'h0, 4'h0, e);
      wait_rsp(n_rsp + 1);
      wait_idle();
      vec_cnt++;
      if (rsp_q.size() != n_rsp + 1 || rsp_q[n_rsp].data !== 16'h1234 || rsp_q[n_rsp].last !== 1'b1) begin
         err_cnt++; $display("FAIL rst_fresh_read: got n=%0d data=%h, required n=%0d data=1234 last=1",
                             rsp_q.size(), rsp_q.size() > n_rsp ? rsp_q[n_rsp].data : 16'h0, n_rsp + 1);
      end
   endtask

   task automatic test_hold_valid();
      int k = 0;
      logic [7:0] lasts;
      clear_logs();
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 4'hE; req_len = 4'h3;
      while (acc_q.size() < 2 && k < 200) begin @(negedge clk); k++; end
      req_valid = 1'b0;
      wait_rsp(8);
      wait_idle();
      vec_cnt++;
      if (acc_q.size() != 2) begin
         err_cnt++; $display("FAIL hold_accepts: got %0d accepts, required 2", acc_q.size());
      end
      if (rsp_q.size() == 8 && acc_q.size() == 2) begin
         for (int i = 0; i < 8; i++) lasts[i] = rsp_q[i].last;
         vec_cnt++;
         if (lasts !== 8'b1000_1000) begin
            err_cnt++; $display("FAIL hold_last: got last pattern %b, required 10001000", lasts);
         end
         vec_cnt++;
         if (acc_q[1] <= rsp_q[3].t) begin
            err_cnt++; $display("FAIL hold_second_accept: got accept at %0t, required after %0t", acc_q[1], rsp_q[3].t);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_wrap();
      test_stall();
      test_back_to_back();
      test_reset_mid_burst();
      test_hold_valid();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule

// File: doc/tekram_initiator.md
Name: tekram_initiator

Overview:
Host-side controller that drives the single-port tekram bus (addr, cs, wr, oe, bidirectional data). It converts valid/ready read/write requests into correctly timed RAM bus cycles and returns read data on a valid/ready response channel. It supports single-beat writes and incrementing read bursts, and it inserts a bus turnaround cycle after every operation. It sits between any on-chip master and one tekram instance.

Parameters:
ADDR_WIDTH, 4, RAM address width; addresses wrap modulo 2^ADDR_WIDTH
DATA_WIDTH, 16, RAM data width
LEN_WIDTH, 4, burst length field width; beats = req_len+1

Ports:
clk  input  1  single clock, all logic on posedge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request valid
req_ready  output  1  request accepted when valid&&ready at posedge
req_we  input  1  1=write (single beat, req_len ignored), 0=read burst
req_addr  input  ADDR_WIDTH  start address
req_wdata  input  DATA_WIDTH  write data
req_len  input  LEN_WIDTH  read beats minus one
rsp_valid  output  1  read data valid
rsp_ready  input  1  consumer accepts rsp at posedge
rsp_rdata  output  DATA_WIDTH  read data
rsp_last  output  1  final beat of burst
busy  output  1  state != IDLE
mem_addr  output  ADDR_WIDTH  RAM address, registered
mem_cs  output  1  RAM chip select, registered
mem_wr  output  1  RAM write enable, registered
mem_oe  output  1  RAM output enable, registered
mem_data  inout  DATA_WIDTH  driven with write data only while mem_cs&&mem_wr, else high-Z

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE; mem_cs/mem_wr/mem_oe/mem_addr=0; mem_data released (Z); rsp_valid=0, rsp_last=0, rsp_rdata=0; req_ready=0 while rst_n=0. Reset mid-burst aborts the burst with no further response beats.
- States: IDLE, WR, RD, TURN.
- IDLE: req_ready=1. On accept: latch addr, wdata, beat count, then go to WR if req_we=1, else RD.
- WR: exactly one cycle with cs=1, wr=1, oe=0, addr=A, and the initiator driving mem_data=wdata. The RAM writes at the posedge ending this cycle. Next state TURN.
- RD: a beat is issued in a cycle (cs=1, wr=0, oe=1, addr=current) only if rsp_valid is 0 for that cycle. Otherwise cs=oe=0 (wait cycle, address held).
  - The RAM drives data after the mid-cycle negedge. The initiator captures mem_data into rsp_rdata at the posedge ending the issue cycle and sets rsp_valid=1. rsp_last=1 on the final beat.
  - Address increments by 1 per issued beat and wraps from 2^ADDR_WIDTH-1 to 0.
  - Throughput is at most one beat per 2 cycles (single response slot).
  - After the final beat is captured, next state is TURN.
- TURN: one cycle with cs=wr=oe=0 and the bus undriven by both ends, then IDLE. No cycle ever has the initiator driving while mem_oe=1.
- Response slot: rsp_valid clears on rsp_valid&&rsp_ready unless a new beat is captured on the same edge. rsp_rdata/rsp_last hold stable while rsp_valid&&!rsp_ready.
- Latency:
  - Write: accept edge E, RAM write at E+2, req_ready high again at E+3.
  - Read (slot empty): rsp_valid high after edge E+2.
- req_valid while req_ready=0 is ignored (no queuing). A response still pending from a previous burst stalls issue of the new burst's first beat.

Decomposition:
- Package tekram_pkg: state enum (IDLE, WR, RD, TURN), default width constants ADDR_WIDTH/DATA_WIDTH/LEN_WIDTH, shared with the tekram RAM.
- Flat module; the response slot is optionally split out as sub-module tekram_rsp_slot (one-entry valid/ready register with last flag).

Test Plan:
- Write 0x3←0xBEEF, then read 0x3 len 0 -> mem_wr pulse with mem_data=0xBEEF for 1 cycle; rsp_rdata=0xBEEF, rsp_last=1, rsp_valid at accept+2.
- Preload 0xE,0xF,0x0,0x1 with 0x100E,0x100F,0x1000,0x1001; read 0xE len 3 -> mem_addr E,F,0,1 (wrap); four responses in order; rsp_last only on 0x1001.
- Burst read len 3 with rsp_ready=0 for 5 cycles after the first beat -> no mem_cs during the stall; rsp_rdata held stable; remaining beats resume after rsp_ready=1.
- Read then write back-to-back -> at least one cs=0 TURN cycle between; the initiator never drives mem_data while mem_oe=1 (no X on bus).
- rst_n=0 during beat 2 of len-7 burst -> next edge all mem_* =0, bus Z, rsp_valid=0; after release req_ready=1, and a fresh read returns correct data.
- req_valid held high during a busy burst -> not accepted until IDLE; exactly one accept per handshake.
